// File: rtl/fir_s2p_packer_3_pkg.sv
// ---------------------------------------------------------------------------
// fir_s2p_packer_3_pkg
//   Shared constants and types for the 3-way unfolded FIR datapath: sample
//   width, unfolding factor, slot-counter width and the slot-index encoding
//   used by the serial-to-parallel input packer.
// ---------------------------------------------------------------------------
package fir_s2p_packer_3_pkg;

  // Sample width in bits (two's complement); must match the filter.
  localparam int SAMPLE_W = 14;

  // Unfolding factor: samples per parallel word.
  localparam int P = 3;

  // Width of the slot counter that walks 0..P-1.
  localparam int CNT_W = $clog2(P);

  // Width of the "number of real samples" field (values 1..P).
  localparam int NV_W = 2;

  // Slot index: which position of the group the next valid sample fills.
  typedef enum logic [CNT_W-1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2
  } slot_e;

endpackage

// File: rtl/fir_s2p_packer_3_if.sv
// ---------------------------------------------------------------------------
// fir_s2p_packer_3_if
//   Sample-source -> packer -> filter bus.
//   master : sample source side (drives DIN/Vin/Flush, observes the group)
//   slave  : packer side (consumes DIN/Vin/Flush, drives DOUT_1..3/Vout/Nvalid)
//   DIN    : serial input sample             Vin    : DIN valid this cycle
//   Flush  : emit pending partial group      DOUT_n : packed group, oldest first
//   Vout   : one-cycle new-group strobe      Nvalid : real samples in group
// ---------------------------------------------------------------------------
interface fir_s2p_packer_3_if
  import fir_s2p_packer_3_pkg::*;
#(
  parameter int NB = SAMPLE_W
);

  logic [NB-1:0]   DIN;
  logic            Vin;
  logic            Flush;
  logic [NB-1:0]   DOUT_1;
  logic [NB-1:0]   DOUT_2;
  logic [NB-1:0]   DOUT_3;
  logic            Vout;
  logic [NV_W-1:0] Nvalid;

  modport master (
    output DIN, Vin, Flush,
    input  DOUT_1, DOUT_2, DOUT_3, Vout, Nvalid
  );

  modport slave (
    input  DIN, Vin, Flush,
    output DOUT_1, DOUT_2, DOUT_3, Vout, Nvalid
  );

endinterface

// File: rtl/fir_s2p_packer_3.sv
// ---------------------------------------------------------------------------
// fir_s2p_packer_3
//   Serial-to-parallel input stage for the 3-way unfolded FIR. Packs three
//   consecutive valid samples into one parallel word with a one-cycle Vout
//   strobe. Flush emits a pending partial group zero-padded, with Nvalid
//   telling the filter how many samples are real. Data pass bit-exact.
//
//   Ports
//     Ck   : clock, rising edge
//     Rst  : asynchronous reset, active-high
//     bus  : fir_s2p_packer_3_if.slave (DIN/Vin/Flush in,
//            DOUT_1..3/Vout/Nvalid out, all registered)
// ---------------------------------------------------------------------------
module fir_s2p_packer_3
  import fir_s2p_packer_3_pkg::*;
#(
  parameter int NB = SAMPLE_W
) (
  input  logic                  Ck,
  input  logic                  Rst,
  fir_s2p_packer_3_if.slave     bus
);

  // Slot state: how many samples are held, and the two holding slots.
  slot_e           r_cnt;
  logic [NB-1:0]   r_s0;
  logic [NB-1:0]   r_s1;

  // Registered outputs.
  logic [NB-1:0]   r_dout_1;
  logic [NB-1:0]   r_dout_2;
  logic [NB-1:0]   r_dout_3;
  logic            r_vout;
  logic [NV_W-1:0] r_nvalid;

  // Next-state / next-output decisions.
  slot_e           w_cnt_nxt;
  logic [NB-1:0]   w_s0_nxt;
  logic [NB-1:0]   w_s1_nxt;
  logic            w_emit;
  logic [NB-1:0]   w_d1;
  logic [NB-1:0]   w_d2;
  logic [NB-1:0]   w_d3;
  logic [NV_W-1:0] w_nvalid;

  // The incoming sample is always placed before a flush is honoured, so a
  // Flush with Vin=1 closes the group that includes the current DIN.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_cnt_nxt = r_cnt;
    w_s0_nxt  = r_s0;
    w_s1_nxt  = r_s1;
    w_emit    = 1'b0;
    w_d1      = '0;
    w_d2      = '0;
    w_d3      = '0;
    w_nvalid  = '0;

    if (bus.Vin) begin
      case (r_cnt)
        SLOT_0: begin
          if (bus.Flush) begin
            w_emit    = 1'b1;
            w_d1      = bus.DIN;
            w_nvalid  = 2'd1;
            w_cnt_nxt = SLOT_0;
          end else begin
            w_s0_nxt  = bus.DIN;
            w_cnt_nxt = SLOT_1;
          end
        end
        SLOT_1: begin
          if (bus.Flush) begin
            w_emit    = 1'b1;
            w_d1      = r_s0;
            w_d2      = bus.DIN;
            w_nvalid  = 2'd2;
            w_cnt_nxt = SLOT_0;
          end else begin
            w_s1_nxt  = bus.DIN;
            w_cnt_nxt = SLOT_2;
          end
        end
        SLOT_2: begin
          // Third sample completes the group whether or not Flush is set.
          w_emit    = 1'b1;
          w_d1      = r_s0;
          w_d2      = r_s1;
          w_d3      = bus.DIN;
          w_nvalid  = 2'd3;
          w_cnt_nxt = SLOT_0;
        end
        default: w_cnt_nxt = SLOT_0;
      endcase
    end else if (bus.Flush) begin
      case (r_cnt)
        SLOT_1: begin
          w_emit   = 1'b1;
          w_d1     = r_s0;
          w_nvalid = 2'd1;
        end
        SLOT_2: begin
          w_emit   = 1'b1;
          w_d1     = r_s0;
          w_d2     = r_s1;
          w_nvalid = 2'd2;
        end
        default: ; // nothing pending: flush is a no-op
      endcase
      w_cnt_nxt = SLOT_0;
    end
  end

  // Slot counter and holding slots.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      // NOTE: the holding slots are plain flops (two words), so they are
      // reset with everything else; a mid-group reset leaves no residue.
      r_cnt <= SLOT_0;
      r_s0  <= '0;
      r_s1  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_cnt <= w_cnt_nxt;
      r_s0  <= w_s0_nxt;
      r_s1  <= w_s1_nxt;
    end
  end

  // Output register: Vout is a pulse, the group words hold until replaced.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      r_dout_1 <= '0;
      r_dout_2 <= '0;
      r_dout_3 <= '0;
      r_vout   <= 1'b0;
      r_nvalid <= '0;
    end else begin
      r_vout <= w_emit;
      if (w_emit) begin
        r_dout_1 <= w_d1;
        r_dout_2 <= w_d2;
        r_dout_3 <= w_d3;
        r_nvalid <= w_nvalid;
      end
    end
  end

  assign bus.DOUT_1 = r_dout_1;
  assign bus.DOUT_2 = r_dout_2;
  assign bus.DOUT_3 = r_dout_3;
  assign bus.Vout   = r_vout;
  assign bus.Nvalid = r_nvalid;

endmodule

// File: tb/tb_fir_s2p_packer_3.sv
// ---------------------------------------------------------------------------
// tb_fir_s2p_packer_3
//   Self-checking bench for fir_s2p_packer_3. A queue-based reference model
//   collects valid samples and closes a group at three samples or on Flush.
//   A vector table covers the basic stream and extreme values; hand-written
//   sequences cover gaps, flush variants and asynchronous reset; a random
//   phase exercises everything against the model.
// ---------------------------------------------------------------------------
module tb_fir_s2p_packer_3;
  import fir_s2p_packer_3_pkg::*;

  localparam int NB = SAMPLE_W;

  logic clk;
  logic rst;

  fir_s2p_packer_3_if #(.NB(NB)) bus ();

  fir_s2p_packer_3 #(.NB(NB)) dut (
    .Ck  (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // ---------------- reference model ----------------
  logic [NB-1:0]   q[$];
  logic            m_vout;
  logic [NB-1:0]   m_d1, m_d2, m_d3;
  logic [NV_W-1:0] m_nv;

  task automatic model_reset();
    q.delete();
    m_vout = 1'b0;
    m_d1 = '0; m_d2 = '0; m_d3 = '0; m_nv = '0;
  endtask

  task automatic model_step(input logic vin, input logic flush, input logic [NB-1:0] din);
    m_vout = 1'b0;
    if (vin) q.push_back(din);
    if (q.size() == 3 || (flush && q.size() > 0)) begin
      m_vout = 1'b1;
      m_nv   = NV_W'(q.size());
      m_d1   = q[0];
      m_d2   = (q.size() > 1) ? q[1] : '0;
      m_d3   = (q.size() > 2) ? q[2] : '0;
      q.delete();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_group();
    return 64'({bus.DOUT_1, bus.DOUT_2, bus.DOUT_3, bus.Nvalid});
  endfunction

  function automatic logic [63:0] pack_group(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                             input logic [NB-1:0] c, input logic [NV_W-1:0] n);
    return 64'({a, b, c, n});
  endfunction

  task automatic check_model(input string name);
    check({name, "_vout"},  64'(bus.Vout), 64'(m_vout));
    check({name, "_group"}, dut_group(), pack_group(m_d1, m_d2, m_d3, m_nv));
  endtask

  // One clock of stimulus; outputs are stable #1 after the edge.
  task automatic drive(input logic vin, input logic flush, input logic [NB-1:0] din);
    bus.Vin   = vin;
    bus.Flush = flush;
    bus.DIN   = din;
    @(posedge clk);
    #1;
    model_step(vin, flush, din);
    bus.Vin   = 1'b0;
    bus.Flush = 1'b0;
    bus.DIN   = '0;
  endtask

  task automatic drive_chk(input logic vin, input logic flush, input logic [NB-1:0] din,
                           input string name);
    drive(vin, flush, din);
    check_model(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            vin;
    logic            flush;
    logic [NB-1:0]   din;
    logic            e_vout;
    logic [NB-1:0]   e_d1;
    logic [NB-1:0]   e_d2;
    logic [NB-1:0]   e_d3;
    logic [NV_W-1:0] e_nv;
  } vec_t;

  vec_t tbl[12];

  initial begin
    n_vec = 0;
    n_err = 0;

    // Stream 1..6, then extremes -8192, 8191, -1, then three idle cycles.
    tbl[0]  = '{1'b1, 1'b0, 14'd1,     1'b0, 14'd0,     14'd0,     14'd0,     2'd0};
    tbl[1]  = '{1'b1, 1'b0, 14'd2,     1'b0, 14'd0,     14'd0,     14'd0,     2'd0};
    tbl[2]  = '{1'b1, 1'b0, 14'd3,     1'b1, 14'd1,     14'd2,     14'd3,     2'd3};
    tbl[3]  = '{1'b1, 1'b0, 14'd4,     1'b0, 14'd1,     14'd2,     14'd3,     2'd3};
    tbl[4]  = '{1'b1, 1'b0, 14'd5,     1'b0, 14'd1,     14'd2,     14'd3,     2'd3};
    tbl[5]  = '{1'b1, 1'b0, 14'd6,     1'b1, 14'd4,     14'd5,     14'd6,     2'd3};
    tbl[6]  = '{1'b1, 1'b0, 14'h2000,  1'b0, 14'd4,     14'd5,     14'd6,     2'd3};
    tbl[7]  = '{1'b1, 1'b0, 14'h1FFF,  1'b0, 14'd4,     14'd5,     14'd6,     2'd3};
    tbl[8]  = '{1'b1, 1'b0, 14'h3FFF,  1'b1, 14'h2000,  14'h1FFF,  14'h3FFF,  2'd3};
    tbl[9]  = '{1'b0, 1'b0, 14'd0,     1'b0, 14'h2000,  14'h1FFF,  14'h3FFF,  2'd3};
    tbl[10] = '{1'b0, 1'b1, 14'd0,     1'b0, 14'h2000,  14'h1FFF,  14'h3FFF,  2'd3};
    tbl[11] = '{1'b0, 1'b0, 14'd0,     1'b0, 14'h2000,  14'h1FFF,  14'h3FFF,  2'd3};

    bus.Vin   = 1'b0;
    bus.Flush = 1'b0;
    bus.DIN   = '0;
    model_reset();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vout",  64'(bus.Vout), 64'd0);
    check("reset_group", dut_group(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table phase.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vin, tbl[i].flush, tbl[i].din);
      check($sformatf("tbl%0d_vout", i), 64'(bus.Vout), 64'(tbl[i].e_vout));
      check($sformatf("tbl%0d_group", i), dut_group(),
            pack_group(tbl[i].e_d1, tbl[i].e_d2, tbl[i].e_d3, tbl[i].e_nv));
    end

    // Gapped input: 10, idle, 20, idle, idle, 30.
    drive_chk(1'b1, 1'b0, 14'd10, "gap_a");
    drive_chk(1'b0, 1'b0, 14'd0,  "gap_b");
    drive_chk(1'b1, 1'b0, 14'd20, "gap_c");
    drive_chk(1'b0, 1'b0, 14'd0,  "gap_d");
    drive_chk(1'b0, 1'b0, 14'd0,  "gap_e");
    drive_chk(1'b1, 1'b0, 14'd30, "gap_f");
    check("gap_result", 64'({bus.Vout, dut_group()}),
          64'({1'b1, pack_group(14'd10, 14'd20, 14'd30, 2'd3)}));

    // Samples 7,8 then Flush alone -> (7,8,0) Nvalid 2.
    drive_chk(1'b1, 1'b0, 14'd7, "fl_a");
    drive_chk(1'b1, 1'b0, 14'd8, "fl_b");
    drive_chk(1'b0, 1'b1, 14'd0, "fl_c");
    check("fl_partial2", 64'({bus.Vout, dut_group()}),
          64'({1'b1, pack_group(14'd7, 14'd8, 14'd0, 2'd2)}));
    drive_chk(1'b1, 1'b0, 14'd9,  "fl_d");
    drive_chk(1'b1, 1'b0, 14'd10, "fl_e");
    drive_chk(1'b1, 1'b0, 14'd11, "fl_f");
    check("fl_full", dut_group(), pack_group(14'd9, 14'd10, 14'd11, 2'd3));
    drive_chk(1'b0, 1'b1, 14'd0, "fl_empty");
    check("fl_empty_novout", 64'(bus.Vout), 64'd0);

    // Single sample then Flush alone -> (s,0,0) Nvalid 1.
    drive_chk(1'b1, 1'b0, 14'h155, "fl1_a");
    drive_chk(1'b0, 1'b1, 14'd0,   "fl1_b");
    check("fl_partial1", dut_group(), pack_group(14'h155, 14'd0, 14'd0, 2'd1));

    // Flush together with a sample.
    drive_chk(1'b1, 1'b0, 14'd5, "fv_a");
    drive_chk(1'b1, 1'b1, 14'd6, "fv_b");
    check("fv_cnt1", dut_group(), pack_group(14'd5, 14'd6, 14'd0, 2'd2));
    drive_chk(1'b1, 1'b0, 14'd1, "fv_c");
    drive_chk(1'b1, 1'b0, 14'd2, "fv_d");
    drive_chk(1'b1, 1'b1, 14'd3, "fv_e");
    check("fv_cnt2", dut_group(), pack_group(14'd1, 14'd2, 14'd3, 2'd3));
    drive_chk(1'b1, 1'b1, 14'd77, "fv_f");
    check("fv_cnt0", dut_group(), pack_group(14'd77, 14'd0, 14'd0, 2'd1));

    // Asynchronous reset mid-group and mid-cycle.
    drive_chk(1'b1, 1'b0, 14'd4, "ar_a");
    drive_chk(1'b1, 1'b0, 14'd4, "ar_b");
    #2;
    rst = 1'b1;
    #1;
    check("ar_vout_now",  64'(bus.Vout), 64'd0);
    check("ar_group_now", dut_group(), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_chk(1'b1, 1'b0, 14'd1, "ar_c");
    drive_chk(1'b1, 1'b0, 14'd2, "ar_d");
    drive_chk(1'b1, 1'b0, 14'd3, "ar_e");
    check("ar_clean", 64'({bus.Vout, dut_group()}),
          64'({1'b1, pack_group(14'd1, 14'd2, 14'd3, 2'd3)}));

    // Random phase against the model.
    for (int i = 0; i < 500; i++) begin
      logic            r_vin;
      logic            r_flush;
      logic [NB-1:0]   r_din;
      r_vin   = ($urandom_range(0, 99) < 60);
      r_flush = ($urandom_range(0, 7) == 0);
      r_din   = NB'($urandom);
      drive_chk(r_vin, r_flush, r_din, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
